// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-road traffic timer.
package traffic_pkg;

    // Width of the seconds-remaining outputs and the phase counter.
    localparam int TIME_W = 5;

    // Light sequencer phases; NIGHT is the flashing-yellow override.
    typedef enum logic [2:0] {
        MG    = 3'd0,
        MY    = 3'd1,
        SG    = 3'd2,
        SY    = 3'd3,
        NIGHT = 3'd4
    } phase_t;

    // Light encodings as {red, yellow, green}.
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

endpackage

// File: rtl/sec_prescaler.sv
// Free-running clock divider producing a one-cycle pulse every TICK_DIV cycles.
module sec_prescaler
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic rst_n,
    output logic sec_tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;

    // Count 0..TICK_DIV-1 and wrap; only reset restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Tick is decoded from the registered count, so it is glitch-free and one cycle wide.
    assign sec_tick = (div_cnt == LAST);

endmodule

// File: rtl/traffic_timer.sv
// Four-phase traffic-light sequencer with night flashing mode and countdown outputs.
module traffic_timer
    import traffic_pkg::*;
#(
    parameter int TICK_DIV   = 100000000,
    parameter int MAIN_GREEN = 25,
    parameter int SUB_GREEN  = 15,
    parameter int YELLOW     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              night,
    output logic [TIME_W-1:0] main_rest_time,
    output logic [TIME_W-1:0] sub_rest_time,
    output logic [2:0]        main_light,
    output logic [2:0]        sub_light,
    output logic              dis,
    output logic              non,
    output logic              sec_tick
);

    localparam logic [TIME_W-1:0] T_MAIN = TIME_W'(MAIN_GREEN);
    localparam logic [TIME_W-1:0] T_SUB  = TIME_W'(SUB_GREEN);
    localparam logic [TIME_W-1:0] T_YEL  = TIME_W'(YELLOW);
    localparam logic [TIME_W-1:0] T_ONE  = TIME_W'(1);

    phase_t            phase, phase_nxt;
    logic [TIME_W-1:0] cnt, cnt_nxt;
    logic              blink, blink_nxt;

    sec_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .sec_tick (sec_tick)
    );

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase <= MG;
            cnt   <= T_MAIN;
            blink <= 1'b0;
        end else begin
            phase <= phase_nxt;
            cnt   <= cnt_nxt;
            blink <= blink_nxt;
        end
    end

    // Next-state: night request beats the tick; a tick on the night-entry edge is dropped.
    always_comb begin
        phase_nxt = phase;
        cnt_nxt   = cnt;
        blink_nxt = blink;
        if (night) begin
            if (phase != NIGHT) begin
                phase_nxt = NIGHT;
                blink_nxt = 1'b0;
            end else if (sec_tick) begin
                blink_nxt = ~blink;
            end
        end else if (phase == NIGHT) begin
            phase_nxt = MG;
            cnt_nxt   = T_MAIN;
            blink_nxt = 1'b0;
        end else if (sec_tick) begin
            if (cnt > T_ONE) begin
                cnt_nxt = cnt - 1'b1;
            end else begin
                case (phase)
                    MG: begin
                        phase_nxt = MY;
                        cnt_nxt   = T_YEL;
                    end
                    MY: begin
                        phase_nxt = SG;
                        cnt_nxt   = T_SUB;
                    end
                    SG: begin
                        phase_nxt = SY;
                        cnt_nxt   = T_YEL;
                    end
                    default: begin
                        phase_nxt = MG;
                        cnt_nxt   = T_MAIN;
                    end
                endcase
            end
        end
    end

    // Output decode from registered phase/cnt/blink only; the red road also waits out the yellow.
    always_comb begin
        main_light     = OFF;
        sub_light      = OFF;
        main_rest_time = cnt;
        sub_rest_time  = cnt;
        dis            = 1'b1;
        non            = 1'b0;
        case (phase)
            MG: begin
                main_light    = GRN;
                sub_light     = RED;
                sub_rest_time = cnt + T_YEL;
            end
            MY: begin
                main_light = YEL;
                sub_light  = RED;
            end
            SG: begin
                main_light     = RED;
                sub_light      = GRN;
                main_rest_time = cnt + T_YEL;
            end
            SY: begin
                main_light = RED;
                sub_light  = YEL;
            end
            NIGHT: begin
                main_light     = blink ? YEL : OFF;
                sub_light      = blink ? YEL : OFF;
                main_rest_time = '0;
                sub_rest_time  = '0;
                dis            = 1'b0;
                non            = blink;
            end
            default: begin
                main_light = OFF;
                sub_light  = OFF;
            end
        endcase
    end

endmodule
